// File: rtl/dma_collect.sv
// Round-robin collector: drains whole packets from NUM_PE show-ahead FIFO pairs
// into one registered beat stream, checking each packet's byte count.
module dma_collect #(
  parameter int NUM_PE = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NUM_PE-1:0]     i_pkt_empty,
  input  logic [NUM_PE*134-1:0] i_pkt,
  output logic [NUM_PE-1:0]     o_pkt_rden,
  input  logic [NUM_PE-1:0]     i_length_empty,
  input  logic [NUM_PE*16-1:0]  i_length,
  output logic [NUM_PE-1:0]     o_length_rden,
  input  logic                  i_alf,
  output logic                  o_pkt_valid,
  output logic [133:0]          o_pkt,
  output logic                  d_state_1b,
  output logic [2:0]            d_cur_pe_3b,
  output logic [15:0]           d_len_err_16b,
  output logic [31:0]           d_pkt_cnt_32b
);

  typedef enum logic {
    IDLE_S = 1'b0,
    SEND_S = 1'b1
  } state_t;

  state_t        state, state_next;
  logic [2:0]    rr_ptr, cur_pe;
  logic [2:0]    grant, grant_next_ptr;
  logic          grant_vld;
  logic [15:0]   grant_len;
  logic [15:0]   exp_len, byte_cnt, beat_bytes, byte_cnt_next;
  logic [133:0]  sel_pkt;
  logic          sel_empty;
  logic          pop, pop_tail;

  // Search upward from rr_ptr: first the PEs at or above it, then wrap to the lower ones.
  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    grant_len = '0;
    for (int k = 0; k < NUM_PE; k++) begin
      if (!grant_vld && 3'(k) >= rr_ptr && !i_length_empty[k]) begin
        grant_vld = 1'b1;
        grant     = 3'(k);
        grant_len = i_length[k*16 +: 16];
      end
    end
    for (int k = 0; k < NUM_PE; k++) begin
      if (!grant_vld && 3'(k) < rr_ptr && !i_length_empty[k]) begin
        grant_vld = 1'b1;
        grant     = 3'(k);
        grant_len = i_length[k*16 +: 16];
      end
    end
  end

  assign grant_next_ptr = (grant == 3'(NUM_PE - 1)) ? 3'd0 : grant + 3'd1;

  always_comb begin
    sel_empty = 1'b1;
    sel_pkt   = '0;
    for (int k = 0; k < NUM_PE; k++) begin
      if (3'(k) == cur_pe) begin
        sel_empty = i_pkt_empty[k];
        sel_pkt   = i_pkt[k*134 +: 134];
      end
    end
  end

  // A tail nibble of zero stands for a full 16-byte beat.
  assign pop_tail      = (sel_pkt[133:132] == 2'b10);
  assign beat_bytes    = (!pop_tail || sel_pkt[131:128] == 4'd0) ? 16'd16 : {12'd0, sel_pkt[131:128]};
  assign byte_cnt_next = byte_cnt + beat_bytes;

  always_comb begin
    state_next    = state;
    o_length_rden = '0;
    o_pkt_rden    = '0;
    pop           = 1'b0;
    if (!i_rst) begin
      unique case (state)
        IDLE_S: begin
          if (grant_vld) begin
            for (int k = 0; k < NUM_PE; k++) begin
              if (3'(k) == grant) o_length_rden[k] = 1'b1;
            end
            state_next = SEND_S;
          end
        end
        SEND_S: begin
          if (!sel_empty && !i_alf) begin
            pop = 1'b1;
            for (int k = 0; k < NUM_PE; k++) begin
              if (3'(k) == cur_pe) o_pkt_rden[k] = 1'b1;
            end
            if (pop_tail) state_next = IDLE_S;
          end
        end
        default: state_next = IDLE_S;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE_S;
    else       state <= state_next;
  end

  // Length mismatches are only counted; the packet itself is always forwarded untouched.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_pkt_valid   <= 1'b0;
      o_pkt         <= '0;
      rr_ptr        <= '0;
      cur_pe        <= '0;
      exp_len       <= '0;
      byte_cnt      <= '0;
      d_len_err_16b <= '0;
      d_pkt_cnt_32b <= '0;
    end else begin
      o_pkt_valid <= pop;
      if (pop) o_pkt <= sel_pkt;
      if (state == IDLE_S && grant_vld) begin
        cur_pe   <= grant;
        exp_len  <= grant_len;
        byte_cnt <= '0;
        rr_ptr   <= grant_next_ptr;
      end
      if (pop) begin
        byte_cnt <= byte_cnt_next;
        if (pop_tail) begin
          d_pkt_cnt_32b <= d_pkt_cnt_32b + 32'd1;
          if (byte_cnt_next != exp_len && d_len_err_16b != 16'hFFFF)
            d_len_err_16b <= d_len_err_16b + 16'd1;
        end
      end
    end
  end

  assign d_state_1b  = state;
  assign d_cur_pe_3b = cur_pe;

endmodule

// File: tb/tb_dma_collect.sv
// Directed bench for dma_collect: per-PE show-ahead FIFO models feed the DUT and
// a negedge monitor logs grants and output beats for the scenario tasks to check.
module tb_dma_collect;
  localparam int NPE = 3;

  logic               i_clk;
  logic               i_rst;
  logic [NPE-1:0]     i_pkt_empty;
  logic [NPE*134-1:0] i_pkt;
  logic [NPE-1:0]     o_pkt_rden;
  logic [NPE-1:0]     i_length_empty;
  logic [NPE*16-1:0]  i_length;
  logic [NPE-1:0]     o_length_rden;
  logic               i_alf;
  logic               o_pkt_valid;
  logic [133:0]       o_pkt;
  logic               d_state_1b;
  logic [2:0]         d_cur_pe_3b;
  logic [15:0]        d_len_err_16b;
  logic [31:0]        d_pkt_cnt_32b;

  int checks = 0;
  int errors = 0;

  dma_collect #(.NUM_PE(NPE)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_pkt_empty(i_pkt_empty), .i_pkt(i_pkt), .o_pkt_rden(o_pkt_rden),
    .i_length_empty(i_length_empty), .i_length(i_length), .o_length_rden(o_length_rden),
    .i_alf(i_alf), .o_pkt_valid(o_pkt_valid), .o_pkt(o_pkt),
    .d_state_1b(d_state_1b), .d_cur_pe_3b(d_cur_pe_3b),
    .d_len_err_16b(d_len_err_16b), .d_pkt_cnt_32b(d_pkt_cnt_32b)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // FIFO models: write pointers move only from the test process, read pointers only from the monitor.
  logic [133:0] pmem [NPE][32];
  logic [15:0]  lmem [NPE][8];
  int pwr [NPE] = '{0, 0, 0};
  int prd [NPE] = '{0, 0, 0};
  int lwr [NPE] = '{0, 0, 0};
  int lrd [NPE] = '{0, 0, 0};

  always_comb begin
    i_pkt_empty    = '0;
    i_pkt          = '0;
    i_length_empty = '0;
    i_length       = '0;
    for (int k = 0; k < NPE; k++) begin
      i_pkt_empty[k]       = (prd[k] == pwr[k]);
      i_pkt[k*134 +: 134]  = pmem[k][prd[k] % 32];
      i_length_empty[k]    = (lrd[k] == lwr[k]);
      i_length[k*16 +: 16] = lmem[k][lrd[k] % 8];
    end
  end

  logic [NPE-1:0] len_pop = '0;
  logic [NPE-1:0] pkt_pop = '0;
  int cyc = 0;
  always @(posedge i_clk) begin
    cyc     <= cyc + 1;
    len_pop <= o_length_rden;
    pkt_pop <= o_pkt_rden;
  end

  logic [133:0] out_beat [128];
  int out_cyc [128];
  int out_cnt = 0;
  int grant_pe [32];
  int grant_cnt = 0;

  always @(negedge i_clk) begin
    for (int k = 0; k < NPE; k++) begin
      if (pkt_pop[k]) prd[k] <= prd[k] + 1;
      if (len_pop[k]) begin
        lrd[k] <= lrd[k] + 1;
        grant_pe[grant_cnt % 32] <= k;
        grant_cnt <= grant_cnt + 1;
      end
    end
    if (o_pkt_valid) begin
      out_beat[out_cnt % 128] <= o_pkt;
      out_cyc[out_cnt % 128]  <= cyc;
      out_cnt <= out_cnt + 1;
    end
  end

  task automatic step();
    @(negedge i_clk);
    #1;
  endtask

  function automatic logic [133:0] mk_beat(int pe, int id, int idx, int n, int nib);
    logic [1:0] tag;
    logic [3:0] nb;
    if (idx == n - 1)  tag = 2'b10;
    else if (idx == 0) tag = 2'b11;
    else               tag = 2'b01;
    nb = (idx == n - 1) ? 4'(nib) : 4'd0;
    return {tag, nb, 8'(pe), 8'(id), 8'(idx), 104'h5A5A_1234_5678_9ABC_DEF0_1357_9B};
  endfunction

  task automatic push_beat(int pe, logic [133:0] b);
    pmem[pe][pwr[pe] % 32] = b;
    pwr[pe] = pwr[pe] + 1;
  endtask

  task automatic push_len(int pe, logic [15:0] l);
    lmem[pe][lwr[pe] % 8] = l;
    lwr[pe] = lwr[pe] + 1;
  endtask

  // The length word goes in last, matching a writer that stores the packet before its length.
  task automatic load_pkt(int pe, int id, int n, int nib, logic [15:0] len);
    for (int i = 0; i < n; i++) push_beat(pe, mk_beat(pe, id, i, n, nib));
    push_len(pe, len);
  endtask

  task automatic wait_out(int target, int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (out_cnt >= target) break;
      step();
    end
    ok = (out_cnt >= target);
  endtask

  task automatic test_reset();
    step();
    step();
    checks++; if (o_pkt_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0b want 0", o_pkt_valid); end
    checks++; if (o_pkt !== 134'd0) begin errors++; $display("[TB] FAIL reset_pkt: got %h want 0", o_pkt); end
    checks++; if (d_state_1b !== 1'b0) begin errors++; $display("[TB] FAIL reset_state: got %0b want 0", d_state_1b); end
    checks++; if (d_len_err_16b !== 16'd0 || d_pkt_cnt_32b !== 32'd0) begin errors++; $display("[TB] FAIL reset_cnts: got %0d/%0d want 0/0", d_len_err_16b, d_pkt_cnt_32b); end
    checks++; if (o_pkt_rden !== 3'b000 || o_length_rden !== 3'b000) begin errors++; $display("[TB] FAIL reset_rden: got %b/%b want 000/000", o_pkt_rden, o_length_rden); end
    i_rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    int ob, gc;
    bit ok;
    ob = out_cnt;
    load_pkt(1, 1, 3, 4, 16'd36);
    #1;
    gc = cyc;
    checks++; if (o_length_rden !== 3'b010) begin errors++; $display("[TB] FAIL single_grant: got %b want 010", o_length_rden); end
    wait_out(ob + 3, 20, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL single_timeout: got %0d beats want 3", out_cnt - ob); end
    checks++; if (out_cyc[ob] !== gc + 2) begin errors++; $display("[TB] FAIL single_latency: got cycle %0d want %0d", out_cyc[ob], gc + 2); end
    checks++; if (out_cyc[ob + 2] !== gc + 4) begin errors++; $display("[TB] FAIL single_last_cycle: got %0d want %0d", out_cyc[ob + 2], gc + 4); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (out_beat[ob + i] !== mk_beat(1, 1, i, 3, 4)) begin errors++; $display("[TB] FAIL single_beat%0d: got %h want %h", i, out_beat[ob + i], mk_beat(1, 1, i, 3, 4)); end
    end
    step();
    step();
    checks++; if (d_pkt_cnt_32b !== 32'd1) begin errors++; $display("[TB] FAIL single_pkt_cnt: got %0d want 1", d_pkt_cnt_32b); end
    checks++; if (d_len_err_16b !== 16'd0) begin errors++; $display("[TB] FAIL single_len_err: got %0d want 0", d_len_err_16b); end
    checks++; if (d_state_1b !== 1'b0) begin errors++; $display("[TB] FAIL single_idle: got %0b want 0", d_state_1b); end
  endtask

  task automatic test_round_robin();
    int ob, gb;
    bit ok;
    int epe [5];
    int eid [5];
    epe = '{0, 1, 2, 2, 0};
    eid = '{2, 3, 4, 5, 6};
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    ob = out_cnt;
    gb = grant_cnt;
    load_pkt(0, 2, 2, 4, 16'd20);
    load_pkt(1, 3, 2, 4, 16'd20);
    load_pkt(2, 4, 2, 4, 16'd20);
    wait_out(ob + 6, 40, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL rr_timeout1: got %0d beats want 6", out_cnt - ob); end
    step();
    // PE2 alone is granted first; PE0 arrives while PE2 is being drained.
    load_pkt(2, 5, 2, 4, 16'd20);
    step();
    load_pkt(0, 6, 2, 4, 16'd20);
    wait_out(ob + 10, 40, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL rr_timeout2: got %0d beats want 10", out_cnt - ob); end
    step();
    step();
    checks++; if (grant_cnt !== gb + 5) begin errors++; $display("[TB] FAIL rr_grants: got %0d want 5", grant_cnt - gb); end
    for (int p = 0; p < 5; p++) begin
      checks++; if (grant_pe[gb + p] !== epe[p]) begin errors++; $display("[TB] FAIL rr_order%0d: got PE%0d want PE%0d", p, grant_pe[gb + p], epe[p]); end
      for (int b = 0; b < 2; b++) begin
        checks++; if (out_beat[ob + 2*p + b] !== mk_beat(epe[p], eid[p], b, 2, 4)) begin errors++; $display("[TB] FAIL rr_beat%0d_%0d: got %h want %h", p, b, out_beat[ob + 2*p + b], mk_beat(epe[p], eid[p], b, 2, 4)); end
      end
    end
    checks++; if (out_cyc[ob + 2] - out_cyc[ob + 1] !== 2) begin errors++; $display("[TB] FAIL rr_gap: got %0d want 2", out_cyc[ob + 2] - out_cyc[ob + 1]); end
    checks++; if (d_pkt_cnt_32b !== 32'd5) begin errors++; $display("[TB] FAIL rr_pkt_cnt: got %0d want 5", d_pkt_cnt_32b); end
  endtask

  task automatic test_alf_stall();
    int ob;
    bit ok;
    ob = out_cnt;
    load_pkt(0, 7, 4, 0, 16'd64);
    wait_out(ob + 2, 20, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL alf_timeout1: got %0d beats want 2", out_cnt - ob); end
    i_alf = 1'b1;
    #1;
    checks++; if (d_state_1b !== 1'b1) begin errors++; $display("[TB] FAIL alf_state: got %0b want 1", d_state_1b); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (o_pkt_rden !== 3'b000) begin errors++; $display("[TB] FAIL alf_rden%0d: got %b want 000", i, o_pkt_rden); end
      step();
      checks++; if (o_pkt_valid !== 1'b0) begin errors++; $display("[TB] FAIL alf_valid%0d: got %0b want 0", i, o_pkt_valid); end
    end
    i_alf = 1'b0;
    wait_out(ob + 4, 20, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL alf_timeout2: got %0d beats want 4", out_cnt - ob); end
    step();
    step();
    checks++; if (out_cnt !== ob + 4) begin errors++; $display("[TB] FAIL alf_count: got %0d want 4", out_cnt - ob); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_beat[ob + i] !== mk_beat(0, 7, i, 4, 0)) begin errors++; $display("[TB] FAIL alf_beat%0d: got %h want %h", i, out_beat[ob + i], mk_beat(0, 7, i, 4, 0)); end
    end
    checks++; if (out_cyc[ob + 2] - out_cyc[ob + 1] !== 6) begin errors++; $display("[TB] FAIL alf_gap: got %0d want 6", out_cyc[ob + 2] - out_cyc[ob + 1]); end
    checks++; if (d_pkt_cnt_32b !== 32'd6) begin errors++; $display("[TB] FAIL alf_pkt_cnt: got %0d want 6", d_pkt_cnt_32b); end
  endtask

  task automatic test_len_err();
    int ob;
    bit ok;
    ob = out_cnt;
    load_pkt(1, 8, 3, 0, 16'd40);
    wait_out(ob + 3, 20, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL lenerr_timeout: got %0d beats want 3", out_cnt - ob); end
    step();
    step();
    checks++; if (dut.byte_cnt !== 16'd48) begin errors++; $display("[TB] FAIL lenerr_byte_cnt: got %0d want 48", dut.byte_cnt); end
    checks++; if (d_len_err_16b !== 16'd1) begin errors++; $display("[TB] FAIL lenerr_count: got %0d want 1", d_len_err_16b); end
    checks++; if (d_pkt_cnt_32b !== 32'd7) begin errors++; $display("[TB] FAIL lenerr_pkt_cnt: got %0d want 7", d_pkt_cnt_32b); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (out_beat[ob + i] !== mk_beat(1, 8, i, 3, 0)) begin errors++; $display("[TB] FAIL lenerr_beat%0d: got %h want %h", i, out_beat[ob + i], mk_beat(1, 8, i, 3, 0)); end
    end
  endtask

  task automatic test_empty_stall();
    int ob;
    bit ok;
    ob = out_cnt;
    push_beat(2, mk_beat(2, 9, 0, 2, 4));
    push_len(2, 16'd20);
    #1;
    checks++; if (o_length_rden !== 3'b100) begin errors++; $display("[TB] FAIL empty_grant: got %b want 100", o_length_rden); end
    step();
    step();
    for (int i = 0; i < 3; i++) begin
      checks++; if (o_pkt_rden !== 3'b000 || d_state_1b !== 1'b1) begin errors++; $display("[TB] FAIL empty_stall%0d: got rden %b state %0b want 000/1", i, o_pkt_rden, d_state_1b); end
      step();
    end
    push_beat(2, mk_beat(2, 9, 1, 2, 4));
    wait_out(ob + 2, 20, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL empty_timeout: got %0d beats want 2", out_cnt - ob); end
    step();
    step();
    for (int i = 0; i < 2; i++) begin
      checks++; if (out_beat[ob + i] !== mk_beat(2, 9, i, 2, 4)) begin errors++; $display("[TB] FAIL empty_beat%0d: got %h want %h", i, out_beat[ob + i], mk_beat(2, 9, i, 2, 4)); end
    end
    checks++; if (d_state_1b !== 1'b0) begin errors++; $display("[TB] FAIL empty_idle: got %0b want 0", d_state_1b); end
    checks++; if (d_pkt_cnt_32b !== 32'd8 || d_len_err_16b !== 16'd1) begin errors++; $display("[TB] FAIL empty_cnts: got %0d/%0d want 8/1", d_pkt_cnt_32b, d_len_err_16b); end
  endtask

  task automatic test_reset_mid();
    int ob;
    bit ok;
    ob = out_cnt;
    load_pkt(1, 10, 4, 8, 16'd56);
    wait_out(ob + 2, 20, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL rstmid_timeout: got %0d beats want 2", out_cnt - ob); end
    i_rst = 1'b1;
    #1;
    checks++; if (o_pkt_rden !== 3'b000 || o_length_rden !== 3'b000) begin errors++; $display("[TB] FAIL rstmid_rden: got %b/%b want 000/000", o_pkt_rden, o_length_rden); end
    step();
    checks++; if (o_pkt_valid !== 1'b0 || o_pkt !== 134'd0) begin errors++; $display("[TB] FAIL rstmid_out: got %0b/%h want 0/0", o_pkt_valid, o_pkt); end
    checks++; if (d_state_1b !== 1'b0 || d_cur_pe_3b !== 3'd0) begin errors++; $display("[TB] FAIL rstmid_state: got %0b/%0d want 0/0", d_state_1b, d_cur_pe_3b); end
    checks++; if (d_len_err_16b !== 16'd0 || d_pkt_cnt_32b !== 32'd0) begin errors++; $display("[TB] FAIL rstmid_cnts: got %0d/%0d want 0/0", d_len_err_16b, d_pkt_cnt_32b); end
    i_rst = 1'b0;
    step();
    step();
    // Leftover beats of the abandoned packet have no length word, so nothing may be granted.
    checks++; if (d_state_1b !== 1'b0 || o_pkt_rden !== 3'b000) begin errors++; $display("[TB] FAIL rstmid_quiet: got state %0b rden %b want 0/000", d_state_1b, o_pkt_rden); end
    checks++; if (out_cnt !== ob + 2) begin errors++; $display("[TB] FAIL rstmid_beats: got %0d want 2", out_cnt - ob); end
  endtask

  initial begin
    i_rst = 1'b1;
    i_alf = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_alf_stall();
    test_len_err();
    test_empty_stall();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] simulation did not complete");
  end

endmodule

// File: doc/dma_collect.md
DMA_COLLECT -- requirements
Module: dma_collect

Interface
REQ-001 The block SHALL have parameter NUM_PE, default 3, giving the number of PE-side DMA read channels (valid range 1..8).
REQ-002 The block SHALL have port i_clk, input, 1, the single clock for all logic.
REQ-003 The block SHALL have port i_rst, input, 1, a synchronous active-high reset sampled on the rising edge of i_clk.
REQ-004 The block SHALL have port i_pkt_empty, input, NUM_PE, asserted when the show-ahead packet FIFO of PE k holds no beat.
REQ-005 The block SHALL have port i_pkt, input, NUM_PE*134, the head-of-FIFO beat of PE k at [k*134+:134], using tag [133:132]: 11 = head, 01 = body, 10 = tail, and [131:128] = valid bytes in the tail, where 0 means 16.
REQ-006 The block SHALL have port o_pkt_rden, output, NUM_PE, a combinational pop for the packet FIFO of PE k.
REQ-007 The block SHALL have port i_length_empty, input, NUM_PE, asserted when the show-ahead length FIFO of PE k is empty.
REQ-008 The block SHALL have port i_length, input, NUM_PE*16, the head-of-FIFO byte length of PE k at [k*16+:16].
REQ-009 The block SHALL have port o_length_rden, output, NUM_PE, a combinational pop for the length FIFO of PE k.
REQ-010 The block SHALL have port i_alf, input, 1, asserted when the downstream FIFO is almost full.
REQ-011 The block SHALL have port o_pkt_valid, output, 1, a registered beat-valid strobe.
REQ-012 The block SHALL have port o_pkt, output, 134, the registered merged beat.
REQ-013 The block SHALL have port d_state_1b, output, 1, the current state (0 = IDLE_S, 1 = SEND_S).
REQ-014 The block SHALL have port d_cur_pe_3b, output, 3, the index of the PE currently granted.
REQ-015 The block SHALL have port d_len_err_16b, output, 16, a count of length-mismatch packets that saturates at 16'hFFFF.
REQ-016 The block SHALL have port d_pkt_cnt_32b, output, 32, a count of forwarded packets that wraps at 2^32.

Function
REQ-017 The block SHALL treat PE k as a candidate exactly when i_length_empty[k]=0, since a length word is written only after the complete packet is stored.
REQ-018 The block SHALL, in IDLE_S when at least one candidate exists, grant the first candidate found searching upward from rr_ptr modulo NUM_PE.
REQ-019 On a grant the block SHALL, in the same cycle, drive o_length_rden[g]=1 for exactly one cycle, latch cur_pe=g, latch exp_len=i_length[g*16+:16], clear byte_cnt, set rr_ptr=(g+1) mod NUM_PE, and move to SEND_S.
REQ-020 In IDLE_S with no candidate, the block SHALL keep o_length_rden=0 and o_pkt_rden=0 and SHALL leave rr_ptr unchanged.
REQ-021 In SEND_S the block SHALL drive o_pkt_rden[cur_pe]=1 combinationally exactly when i_pkt_empty[cur_pe]=0 and i_alf=0, and all other o_pkt_rden bits SHALL be 0.
REQ-022 For every popped beat the block SHALL drive o_pkt_valid=1 and o_pkt equal to the popped beat on the next cycle, so latency is 1 cycle; in every other cycle o_pkt_valid SHALL be 0 and o_pkt SHALL hold its last value.
REQ-023 In SEND_S, i_alf=1 or i_pkt_empty[cur_pe]=1 SHALL stall the transfer with no pop, no state change and no timeout.
REQ-024 byte_cnt SHALL be 16 bits wide, SHALL add 16 for each popped non-tail beat, and SHALL add the tail valid-byte count (0 counted as 16) for the popped tail, wrapping modulo 2^16.
REQ-025 Popping a tail beat SHALL return the state machine to IDLE_S on the next cycle and SHALL increment d_pkt_cnt_32b.
REQ-026 When the final byte_cnt including the tail differs from exp_len, the block SHALL increment d_len_err_16b (saturating) and SHALL still forward the packet unmodified.
REQ-027 A head or body tag seen in SEND_S SHALL be forwarded as a non-tail beat, so only a tail ends a packet.
REQ-028 Since a grant cycle does not pop data, the block SHALL insert a minimum gap of one idle output cycle between packets.
REQ-029 The block SHALL never pop length and packet FIFOs of different PEs in the same cycle, and SHALL never pop more than one PE per cycle.

Reset
REQ-030 With i_rst=1 at a clock edge, the block SHALL clear o_pkt_valid, o_pkt, rr_ptr, cur_pe, exp_len, byte_cnt, d_len_err_16b and d_pkt_cnt_32b to 0 and SHALL force the state to IDLE_S.
REQ-031 While i_rst=1, o_pkt_rden and o_length_rden SHALL be 0.
REQ-032 A reset during SEND_S SHALL abandon the packet with no further pops, and clearing the FIFOs is the responsibility of the external FIFO reset.

Verification
REQ-033 The bench SHALL load PE1 with head, body and a tail of 4 bytes, length 36, and check o_length_rden[1] in the grant cycle, 3 o_pkt_valid beats starting 2 cycles after the grant, d_pkt_cnt_32b=1 and d_len_err_16b=0.
REQ-034 The bench SHALL load PE0, PE1 and PE2 with one packet each at once and check grant order 0, 1, 2; then, with rr_ptr=0, load only PE2 and PE0 and check order 2 then 0.
REQ-035 The bench SHALL hold i_alf=1 for 5 cycles in the middle of a packet and check no pops and o_pkt_valid=0 during the stall, then resumption with no beat lost or duplicated.
REQ-036 The bench SHALL send a packet of 3 beats with tail nibble 0 and length 40, and check byte_cnt=48 and d_len_err_16b incremented to 1 while the packet is still forwarded intact.
REQ-037 The bench SHALL empty the packet FIFO after the head of a 2-beat packet for 3 cycles and check the stall, then the tail delivered and a return to IDLE_S.
REQ-038 The bench SHALL assert i_rst for 1 cycle after the second beat of a 4-beat packet and check all outputs and counters at 0, the state at IDLE_S, and no pop during reset.
